// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: takes 32-bit words over valid/ready and
// writes them as four little-endian bytes, holding the core until done. Optional: CHECKSUM_EN.
module imem_loader #(
    parameter int InstrWidth = 32,
    parameter int EntryWidth = 8,
    parameter int AddrWidth  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [AddrWidth-1:0]  base_addr,
    input  logic [AddrWidth-2:0]  word_count,
    input  logic                  abort,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [InstrWidth-1:0] s_data,
    input  logic [31:0]           exp_sum,
    output logic                  mem_we,
    output logic [AddrWidth-1:0]  mem_addr,
    output logic [EntryWidth-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  load_err
);

    localparam int CW = AddrWidth - 1;

    typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, DONE} state_e;

    state_e                state_q, state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [AddrWidth-1:0]  cur_addr_q, cur_addr_d;
    logic [CW-1:0]         word_ctr_q, word_ctr_d;
    logic [CW-1:0]         word_cnt_q, word_cnt_d;
    logic [InstrWidth-1:0] data_q, data_d;

    logic                  s_ready_q, s_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [AddrWidth-1:0]  mem_addr_q, mem_addr_d;
    logic [EntryWidth-1:0] mem_wdata_q, mem_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

`ifdef CHECKSUM_EN
    logic [31:0]           sum_q, sum_d;
    logic                  load_err_q, load_err_d;
`else
    logic                  unused_exp_sum;
    assign unused_exp_sum = ^exp_sum;
`endif

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        cur_addr_d  = cur_addr_q;
        word_ctr_d  = word_ctr_q;
        word_cnt_d  = word_cnt_q;
        data_d      = data_q;
        cpu_hold_d  = cpu_hold_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef CHECKSUM_EN
        sum_d       = sum_q;
        load_err_d  = load_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr_d = base_addr;
                    word_cnt_d = word_count;
                    word_ctr_d = '0;
                    cpu_hold_d = 1'b1;
`ifdef CHECKSUM_EN
                    sum_d      = '0;
                    load_err_d = 1'b0;
`endif
                    state_d    = (word_count != '0) ? WAIT_WORD : DONE;
                end
            end
            WAIT_WORD: begin
                if (s_valid) begin
                    data_d     = s_data;
                    byte_idx_d = 2'd0;
`ifdef CHECKSUM_EN
                    sum_d      = sum_q + s_data;
`endif
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    cur_addr_d = cur_addr_q + AddrWidth'(4);
                    word_ctr_d = word_ctr_q + CW'(1);
                    state_d    = (word_ctr_d == word_cnt_q) ? DONE : WAIT_WORD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Verdict is taken on the way into DONE so cpu_hold and load_err land with the done pulse.
        if (state_d == DONE && state_q != DONE) begin
`ifdef CHECKSUM_EN
            load_err_d = (sum_d != exp_sum);
            cpu_hold_d = load_err_d;
`else
            cpu_hold_d = 1'b0;
`endif
        end

        if (abort && state_q != IDLE) begin
            state_d    = IDLE;
            cpu_hold_d = 1'b1;
        end

        s_ready_d = (state_d == WAIT_WORD);
        mem_we_d  = (state_d == WRITE);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        if (state_d == WRITE) begin
            mem_addr_d  = cur_addr_d + {{(AddrWidth-2){1'b0}}, byte_idx_d};
            mem_wdata_d = data_d[EntryWidth*byte_idx_d +: EntryWidth];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_idx_q  <= '0;
            cur_addr_q  <= '0;
            word_ctr_q  <= '0;
            word_cnt_q  <= '0;
            data_q      <= '0;
            s_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            cur_addr_q  <= cur_addr_d;
            word_ctr_q  <= word_ctr_d;
            word_cnt_q  <= word_cnt_d;
            data_q      <= data_d;
            s_ready_q   <= s_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            load_err_q <= load_err_d;
        end
    end
    assign load_err = load_err_q;
`else
    assign load_err = 1'b0;
`endif

    assign s_ready   = s_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected byte writes and done verdicts are queued
// by the stimulus; a negedge monitor pops and compares them.
module tb_imem_loader;
    localparam int AW = 14;
`ifdef CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0, s_valid = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-2:0] word_count = '0;
    logic [31:0]   s_data = '0, exp_sum = '0;
    logic          s_ready, mem_we, cpu_hold, busy, done, load_err;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;

    imem_loader #(.InstrWidth(32), .EntryWidth(8), .AddrWidth(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .abort(abort), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .exp_sum(exp_sum), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    logic [AW+7:0] exp_wr[$];   // {addr, byte}
    logic [1:0]    exp_done[$]; // {cpu_hold, load_err} during the done pulse
    int            hs_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid && s_ready) hs_cyc.push_back(cyc);
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL write: unexpected write addr %0h data %0h", mem_addr, mem_wdata);
                end else chk("write {addr,data}", {mem_addr, mem_wdata}, exp_wr.pop_front());
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done: unexpected done pulse at cycle %0d", cyc);
                end else chk("done {cpu_hold,load_err}", {cpu_hold, load_err}, exp_done.pop_front());
            end
        end
    end

    task automatic push_word(input logic [AW-1:0] a, input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_wr.push_back({AW'(a + AW'(b)), w[8*b +: 8]});
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-2:0] n, output int t);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; word_count = n; t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        s_valid = 1'b1; s_data = w;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL send: s_ready not seen for word %0h", w);
                s_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done(output int t);
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin t = cyc; return; end
        end
        checks++; errors++;
        $display("FAIL wait_done: no done within 200 cycles");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, td, h;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst cpu_hold", cpu_hold, 1);
        chk("rst s_ready", s_ready, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst load_err", load_err, 0);
        rst_n = 1'b1;

        // Single word, little-endian byte order
        exp_sum = 32'hDEADBEEF;
        push_word(14'h000, 32'hDEADBEEF);
        exp_done.push_back(2'b00);
        do_start(14'h000, 13'd1, t);
        chk("t1 busy after start", busy, 1);
        chk("t1 s_ready in WAIT_WORD", s_ready, 1);
        send(32'hDEADBEEF);
        wait_done(td);
        @(negedge clk);
        chk("t1 done one cycle", done, 0);
        chk("t1 cpu_hold released", cpu_hold, 0);
        chk("t1 busy idle", busy, 0);

        // Three words back to back, done 15 cycles after first handshake
        hs_cyc.delete();
        exp_sum = 32'd6;
        push_word(14'h000, 32'd1); push_word(14'h004, 32'd2); push_word(14'h008, 32'd3);
        exp_done.push_back(2'b00);
        do_start(14'h000, 13'd3, t);
        chk("t2 cpu_hold set by start", cpu_hold, 1);
        send(32'd1); send(32'd2); send(32'd3);
        wait_done(td);
        h = (hs_cyc.size() > 0) ? hs_cyc[0] : -1000;
        chk("t2 done latency from handshake", td - h, 15);

        // Address wrap at top of memory
        exp_sum = 32'h6688AACC;
        push_word(14'h3FFC, 32'h11223344); push_word(14'h0000, 32'h55667788);
        exp_done.push_back(2'b00);
        do_start(14'h3FFC, 13'd2, t);
        send(32'h11223344); send(32'h55667788);
        wait_done(td);

        // Abort on byte 2 of the first word; partial write stays, no done
        exp_wr.push_back({14'h100, 8'hA2});
        exp_wr.push_back({14'h101, 8'hA3});
        exp_wr.push_back({14'h102, 8'hA4});
        do_start(14'h100, 13'd2, t);
        send(32'hA5A4A3A2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("t4 mem_we after abort", mem_we, 0);
        chk("t4 busy after abort", busy, 0);
        chk("t4 cpu_hold after abort", cpu_hold, 1);
        chk("t4 s_ready after abort", s_ready, 0);
        repeat (10) @(negedge clk);
        exp_sum = 32'h0BADF00D;
        push_word(14'h200, 32'h0BADF00D);
        exp_done.push_back(2'b00);
        do_start(14'h200, 13'd1, t);
        send(32'h0BADF00D);
        wait_done(td);

        // Zero-length load: done in the cycle after the start cycle, no writes
        exp_sum = 32'd0;
        exp_done.push_back(2'b00);
        do_start(14'h010, 13'd0, t);
        wait_done(td);
        chk("t5 zero-count done latency", td - t, 1);

        // start while busy is ignored (also covers an upstream stall)
        exp_sum = 32'h06080A0C;
        push_word(14'h040, 32'h01020304); push_word(14'h044, 32'h05060708);
        exp_done.push_back(2'b00);
        do_start(14'h040, 13'd2, t);
        send(32'h01020304);
        start = 1'b1; base_addr = 14'h0999; word_count = 13'd1;
        repeat (6) @(posedge clk);
        #1 start = 1'b0;
        chk("t5 busy after ignored start", busy, 1);
        send(32'h05060708);
        wait_done(td);

        // start and abort together in IDLE: start wins
        exp_sum = 32'hCAFEBABE;
        push_word(14'h080, 32'hCAFEBABE);
        exp_done.push_back(2'b00);
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; base_addr = 14'h080; word_count = 13'd1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("t5 start beats abort", busy, 1);
        send(32'hCAFEBABE);
        wait_done(td);

        // Checksum: matching sum releases the core; mismatch holds it when enabled
        exp_sum = 32'd3;
        push_word(14'h300, 32'd1); push_word(14'h304, 32'd2);
        exp_done.push_back(2'b00);
        do_start(14'h300, 13'd2, t);
        send(32'd1); send(32'd2);
        wait_done(td);
        exp_sum = 32'd4;
        push_word(14'h310, 32'd1); push_word(14'h314, 32'd2);
        exp_done.push_back({CHK, CHK});
        do_start(14'h310, 13'd2, t);
        send(32'd1); send(32'd2);
        wait_done(td);
        repeat (3) @(negedge clk);
        chk("t6 load_err held", load_err, CHK);
        chk("t6 cpu_hold after mismatch", cpu_hold, CHK);

        repeat (5) @(negedge clk);
        chk("write queue drained", exp_wr.size(), 0);
        chk("done queue drained", exp_done.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
